// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
//
// Shared constants and types for the FIR data-memory arbiter slice.
//   ADDR_W / DATA_W : dmem address and data widths
//   DEPTH           : number of valid dmem words (legal addresses 0..DEPTH-1)
//   PORT_LDR        : port id of the sample loader
//   PORT_CE         : port id of the coefficient/result engine
//   pipe_entry_t    : bookkeeping that travels with each accepted access
//                     from the issue stage to the response stage
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 10240;

    localparam logic PORT_LDR = 1'b0;
    localparam logic PORT_CE  = 1'b1;

    // One accepted access in flight.
    //   valid : a handshake happened in the previous stage
    //   port  : which requester owns the response
    //   err   : address was out of range, memory was not touched
    //   we    : access was a write (response carries no data)
    typedef struct packed {
        logic valid;
        logic port;
        logic err;
        logic we;
    } pipe_entry_t;

    localparam pipe_entry_t PIPE_IDLE = '{valid: 1'b0, port: 1'b0, err: 1'b0, we: 1'b0};

endpackage : dmem_pkg

// File: rtl/dmem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//
// Two-way combinational grant with a registered last-grant pointer.
//
// Ports:
//   i_clk        : system clock, rising edge
//   i_rst        : asynchronous active-high reset
//   i_valid[1:0] : request valid per port
//   o_grant[1:0] : one-hot (or zero) grant, only ever set on a valid port
//
// Build option:
//   DMEM_ARB_FIXED_PRIO_EN - when defined, port 0 always wins a contention
//   and port 1 is granted only while port 0 is idle. The last-grant pointer
//   is still maintained so both builds share the same state.
// ---------------------------------------------------------------------------
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    // Port that received the most recent grant. Starts at port 1 so that
    // port 0 wins the very first contention after reset.
    logic r_last_grant;

    // Grant is held at zero throughout reset so no requester sees a
    // handshake while the pipeline is being cleared.
    always_comb begin
        o_grant = 2'b00;
        if (!i_rst) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            if (i_valid[0]) begin
                o_grant = 2'b01;
            end else if (i_valid[1]) begin
                o_grant = 2'b10;
            end
`else
            case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                // Contention: serve whichever port did not go last.
                2'b11:   o_grant = (r_last_grant == PORT_CE) ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
`endif
        end
    end

    // Every grant is a handshake (grant implies valid), so the pointer
    // simply follows whichever port was granted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= PORT_CE;
        end else if (|o_grant) begin
            r_last_grant <= o_grant[1];
        end
    end

endmodule : rr_arb2

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter and access sequencer for the single-port FIR data memory.
// Port 0 is the sample loader, port 1 the coefficient/result engine. Accepted
// requests are issued to dmem one cycle after the handshake and answered two
// cycles after the handshake, one access per cycle, in handshake order.
// Out-of-range addresses never reach dmem and are answered with an error.
//
// Ports:
//   i_clk, i_rst          : clock (rising edge), async active-high reset
//   i_req_valid[1:0]      : request valid per port
//   o_req_ready[1:0]      : request accept per port (valid & ready = handshake)
//   i_req_we[1:0]         : 1 = write, 0 = read
//   i_req_addr            : port i address in [i*ADDR_W +: ADDR_W]
//   i_req_wdata           : port i write data in [i*DATA_W +: DATA_W]
//   o_rsp_valid[1:0]      : one-cycle response strobe per port
//   o_rsp_rdata           : read data, 0 for write acks and errors
//   o_rsp_err             : response is an out-of-range error
//   o_mem_cen / o_mem_wen : dmem chip / write enable, both active low
//   o_mem_a / o_mem_d     : dmem address / write data
//   i_mem_q               : dmem read data, valid one cycle after the access
//
// Build option:
//   DMEM_ARB_FIXED_PRIO_EN - strict priority to port 0 instead of round-robin
//   (handled inside rr_arb2; everything else is identical).
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W,
    parameter int DATA_W_P = DATA_W,
    parameter int DEPTH_P  = DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_req_valid,
    output logic [1:0]            o_req_ready,
    input  logic [1:0]            i_req_we,
    input  logic [2*ADDR_W_P-1:0] i_req_addr,
    input  logic [2*DATA_W_P-1:0] i_req_wdata,
    output logic [1:0]            o_rsp_valid,
    output logic [DATA_W_P-1:0]   o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_mem_cen,
    output logic                  o_mem_wen,
    output logic [ADDR_W_P-1:0]   o_mem_a,
    output logic [DATA_W_P-1:0]   o_mem_d,
    input  logic [DATA_W_P-1:0]   i_mem_q
);

    logic [1:0]          w_grant;
    logic                w_hs;
    logic                w_hs_port;
    logic                w_sel_we;
    logic [ADDR_W_P-1:0] w_sel_addr;
    logic [DATA_W_P-1:0] w_sel_wdata;
    logic                w_in_range;

    pipe_entry_t r_issue;
    pipe_entry_t r_resp;

    rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_req_valid),
        .o_grant (w_grant)
    );

    assign o_req_ready = w_grant;
    assign w_hs        = |w_grant;
    assign w_hs_port   = w_grant[1];

    // Steer the granted port's request fields onto a single access.
    assign w_sel_we    = w_hs_port ? i_req_we[1] : i_req_we[0];
    assign w_sel_addr  = w_hs_port ? i_req_addr[ADDR_W_P +: ADDR_W_P]
                                   : i_req_addr[0 +: ADDR_W_P];
    assign w_sel_wdata = w_hs_port ? i_req_wdata[DATA_W_P +: DATA_W_P]
                                   : i_req_wdata[0 +: DATA_W_P];

    // The 14-bit address space reaches 16383 but dmem only has DEPTH words.
    assign w_in_range = ({{(32-ADDR_W_P){1'b0}}, w_sel_addr} < 32'(DEPTH_P));

    // Issue stage: drive dmem for one cycle per handshake. Address and data
    // are only loaded on a real access so idle cycles leave the bus quiet.
    // Out-of-range requests still occupy the pipeline slot so that their
    // error response keeps its place in handshake order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_issue   <= PIPE_IDLE;
            o_mem_cen <= 1'b1;
            o_mem_wen <= 1'b1;
            o_mem_a   <= '0;
            o_mem_d   <= '0;
        end else begin
            r_issue.valid <= w_hs;
            r_issue.port  <= w_hs_port;
            r_issue.err   <= w_hs & ~w_in_range;
            r_issue.we    <= w_hs & w_sel_we;
            if (w_hs && w_in_range) begin
                o_mem_cen <= 1'b0;
                o_mem_wen <= ~w_sel_we;
                o_mem_a   <= w_sel_addr;
                o_mem_d   <= w_sel_wdata;
            end else begin
                o_mem_cen <= 1'b1;
                o_mem_wen <= 1'b1;
            end
        end
    end

    // Response stage bookkeeping. dmem samples at the end of the issue
    // cycle and presents q during the following cycle, which is exactly
    // when this entry is live.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_resp <= PIPE_IDLE;
        end else begin
            r_resp <= r_issue;
        end
    end

    // Read data is taken straight from dmem q rather than re-registered;
    // registering it would add a third cycle of latency.
    always_comb begin
        o_rsp_valid = 2'b00;
        o_rsp_err   = 1'b0;
        o_rsp_rdata = '0;
        if (r_resp.valid) begin
            if (r_resp.port == PORT_CE) begin
                o_rsp_valid = 2'b10;
            end else begin
                o_rsp_valid = 2'b01;
            end
            o_rsp_err = r_resp.err;
            if (!r_resp.err && !r_resp.we) begin
                o_rsp_rdata = i_mem_q;
            end
        end
    end

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter: a behavioural dmem, a transaction-level reference
// model of the arbiter (grant rule, ordered response queue, shadow memory),
// directed scenarios followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  reqValid;
   logic [1:0]  reqReady;
   logic [1:0]  reqWe;
   logic [27:0] reqAddr;
   logic [31:0] reqWdata;
   logic [1:0]  rspValid;
   logic [15:0] rspRdata;
   logic        rspErr;
   logic        memCen;
   logic        memWen;
   logic [13:0] memA;
   logic [15:0] memD;
   logic [15:0] memQ;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (reqValid),
      .o_req_ready (reqReady),
      .i_req_we    (reqWe),
      .i_req_addr  (reqAddr),
      .i_req_wdata (reqWdata),
      .o_rsp_valid (rspValid),
      .o_rsp_rdata (rspRdata),
      .o_rsp_err   (rspErr),
      .o_mem_cen   (memCen),
      .o_mem_wen   (memWen),
      .o_mem_a     (memA),
      .o_mem_d     (memD),
      .i_mem_q     (memQ)
   );

   // Behavioural single-port dmem: write or read on the edge where cen is low,
   // read data appears after that edge.
   logic [15:0] dmemArr [0:DEPTH-1];

   always @(posedge clk) begin
      if (!memCen && (int'(memA) < DEPTH)) begin
         if (!memWen) begin
            dmemArr[memA] = memD;
         end else begin
            memQ <= dmemArr[memA];
         end
      end
   end

   // Reference model state
   typedef struct {
      int due;
      int port;
      int err;
      int data;
   } rsp_t;

   typedef struct {
      int due;
      int we;
      int a;
      int d;
   } iss_t;

   rsp_t rspQ[$];
   iss_t issQ[$];
   int   refMem [0:DEPTH-1];
   logic pendV [2];
   int   pendWe [2];
   int   pendA [2];
   int   pendD [2];
   int   mdlLast;
   int   cyc;
   int   expA;
   int   expD;

   int vecCount  = 0;
   int missCount = 0;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      if (obs !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic setReq(input int p, input int we, input int a, input int d);
      pendV[p]  = 1'b1;
      pendWe[p] = we;
      pendA[p]  = a;
      pendD[p]  = d;
   endtask

   function automatic int pickAddr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return $urandom_range(DEPTH, 16383);
      if (r == 1) return DEPTH - 1;
      if (r == 2) return 0;
      return $urandom_range(100, 115);
   endfunction

   // One clock cycle: check outputs due this cycle, present the pending
   // requests, check the grant and record the resulting handshake.
   task automatic applyStimulus();
      rsp_t r;
      iss_t s;
      int   expV, expErr, expData, expCen, expWen, g;
      @(negedge clk);
      cyc++;

      expV = 0; expErr = 0; expData = 0;
      if (rspQ.size() > 0 && rspQ[0].due == cyc) begin
         r = rspQ.pop_front();
         expV = 1 << r.port;
         expErr = r.err;
         expData = r.data;
      end
      checkOutput("rsp_valid", 32'(rspValid), expV);
      checkOutput("rsp_err", 32'(rspErr), expErr);
      checkOutput("rsp_rdata", 32'(rspRdata), expData);

      expCen = 1; expWen = 1;
      if (issQ.size() > 0 && issQ[0].due == cyc) begin
         s = issQ.pop_front();
         expCen = 0;
         expWen = (s.we != 0) ? 0 : 1;
         expA = s.a;
         expD = s.d;
      end
      checkOutput("mem_cen", 32'(memCen), expCen);
      checkOutput("mem_wen", 32'(memWen), expWen);
      checkOutput("mem_a", 32'(memA), expA);
      checkOutput("mem_d", 32'(memD), expD);

      for (int p = 0; p < 2; p++) begin
         reqValid[p] = pendV[p];
         reqWe[p] = pendWe[p][0];
         reqAddr[p*14 +: 14] = pendA[p][13:0];
         reqWdata[p*16 +: 16] = pendD[p][15:0];
      end
      #1;

      g = -1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      if (pendV[0]) g = 0;
      else if (pendV[1]) g = 1;
`else
      if (pendV[0] && pendV[1]) g = 1 - mdlLast;
      else if (pendV[0]) g = 0;
      else if (pendV[1]) g = 1;
`endif
      checkOutput("req_ready", 32'(reqReady), (g < 0) ? 0 : (1 << g));

      if (g >= 0) begin
         mdlLast = g;
         pendV[g] = 1'b0;
         if (pendA[g] >= DEPTH) begin
            rspQ.push_back('{cyc + 2, g, 1, 0});
         end else begin
            issQ.push_back('{cyc + 1, pendWe[g], pendA[g], pendD[g] & 16'hFFFF});
            if (pendWe[g] != 0) begin
               refMem[pendA[g]] = pendD[g] & 16'hFFFF;
               rspQ.push_back('{cyc + 2, g, 0, 0});
            end else begin
               rspQ.push_back('{cyc + 2, g, 0, refMem[pendA[g]]});
            end
         end
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   initial begin
      int v;
      cyc = 0;
      mdlLast = 1;
      expA = 0;
      expD = 0;
      for (int p = 0; p < 2; p++) begin
         pendV[p] = 1'b0; pendWe[p] = 0; pendA[p] = 0; pendD[p] = 0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         v = int'($urandom_range(0, 65535));
         refMem[i] = v;
         dmemArr[i] = v[15:0];
      end
      refMem[500] = 300;  dmemArr[500] = 16'd300;
      refMem[6000] = 50;  dmemArr[6000] = 16'd50;
      memQ = '0;

      // Reset state, with both requesters already asserting valid
      rst = 1'b1;
      reqValid = 2'b11;
      reqWe = 2'b11;
      reqAddr = {14'd7, 14'd5};
      reqWdata = 32'hABCD_1234;
      #12;
      checkOutput("rst_ready", 32'(reqReady), 0);
      checkOutput("rst_cen", 32'(memCen), 1);
      checkOutput("rst_wen", 32'(memWen), 1);
      checkOutput("rst_a", 32'(memA), 0);
      checkOutput("rst_d", 32'(memD), 0);
      checkOutput("rst_rsp_valid", 32'(rspValid), 0);
      checkOutput("rst_rsp_rdata", 32'(rspRdata), 0);
      checkOutput("rst_rsp_err", 32'(rspErr), 0);
      @(negedge clk);
      reqValid = 2'b00;
      rst = 1'b0;

      // Port 0 writes 9000 to 9999, port 1 reads it back two cycles later
      setReq(0, 1, 9999, 9000);
      idleCycles(2);
      setReq(1, 0, 9999, 0);
      idleCycles(3);

      // Both ports continuously valid: strict alternation 0,1,0,1,0,1
      for (int k = 0; k < 6; k++) begin
         if (!pendV[0]) setReq(0, 0, 500, 0);
         if (!pendV[1]) setReq(1, 0, 6000, 0);
         applyStimulus();
         checkOutput("alt_grant", 32'(reqReady), (k % 2 == 0) ? 1 : 2);
      end
      pendV[0] = 1'b0;
      pendV[1] = 1'b0;
      idleCycles(3);

      // First out-of-range address and last legal address
      setReq(1, 0, DEPTH, 0);
      applyStimulus();
      setReq(0, 0, DEPTH - 1, 0);
      idleCycles(3);

      // Back-to-back write then read of the same word
      setReq(0, 1, 12, 16'h1234);
      applyStimulus();
      setReq(0, 0, 12, 0);
      idleCycles(3);

      // Reset with two reads in flight
      setReq(0, 0, 9999, 0);
      setReq(1, 0, 500, 0);
      idleCycles(2);
      reqValid = 2'b00;
      rst = 1'b1;
      #1;
      checkOutput("midrst_cen", 32'(memCen), 1);
      checkOutput("midrst_rsp_valid", 32'(rspValid), 0);
      checkOutput("midrst_ready", 32'(reqReady), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      rspQ.delete();
      issQ.delete();
      expA = 0;
      expD = 0;
      mdlLast = 1;
      idleCycles(3);
      setReq(0, 0, 9999, 0);
      idleCycles(3);

`ifdef DMEM_ARB_FIXED_PRIO_EN
      // Strict priority: port 1 waits until port 0 drops valid
      for (int k = 0; k < 4; k++) begin
         if (!pendV[0]) setReq(0, 0, 200 + k, 0);
         if (!pendV[1]) setReq(1, 0, 6000, 0);
         applyStimulus();
         checkOutput("prio_no_p1", 32'(reqReady[1]), 0);
      end
      applyStimulus();
      checkOutput("prio_p1_after_drop", 32'(reqReady), 2);
      idleCycles(3);
`endif

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pendV[p] && $urandom_range(0, 3) != 0) begin
               setReq(p, int'($urandom_range(0, 1)), pickAddr(), int'($urandom_range(0, 65535)));
            end
         end
         applyStimulus();
      end

      // Drain, bounded
      for (int k = 0; k < 20; k++) begin
         if (!pendV[0] && !pendV[1] && rspQ.size() == 0 && issQ.size() == 0) break;
         applyStimulus();
      end
      checkOutput("drain_rsp_left", 32'(rspQ.size()), 0);
      checkOutput("drain_pending", 32'({pendV[1], pendV[0]}), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule : tb_dmem_arbiter
